// File: rtl/modular_square_ggg_sequencer.sv
// Control sequencer for the GGG modular-squaring datapath: seeds the datapath,
// gates ce for iterations x SQ_LATENCY enabled cycles, then holds the result for a valid/ready handshake.
module modular_square_ggg_sequencer #(
    parameter int NUM_ELEMENTS = 21,
    parameter int WORD_LEN     = 50,
    parameter int SQ_LATENCY   = 1,
    parameter int ITER_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] iterations,
    input  logic              pause,
    input  logic              abort,
    output logic              load_sq_in,
    output logic              ce,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HOLD
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(SQ_LATENCY - 1);

    generate
        if (SQ_LATENCY < 1 || SQ_LATENCY > 255 || NUM_ELEMENTS < 1 || WORD_LEN < 1 || ITER_W < 1) begin : g_param_check
            $error("modular_square_ggg_sequencer: parameter out of range");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [7:0]          phase_q, phase_d;
    logic [ITER_W-1:0]   iter_count_q, iter_count_d;
    logic [ITER_W-1:0]   target_q, target_d;
    logic [ITER_W:0]     count_inc;

    // One extra bit so the completion compare never sees a wrapped count.
    assign count_inc  = {1'b0, iter_count_q} + {{ITER_W{1'b0}}, 1'b1};
    assign iter_count = iter_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= 8'd0;
            iter_count_q <= '0;
            target_q     <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            iter_count_q <= iter_count_d;
            target_q     <= target_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        iter_count_d = iter_count_q;
        target_d     = target_q;
        load_sq_in   = (state_q == ST_LOAD);
        ce           = (state_q == ST_LOAD) || ((state_q == ST_RUN) && !pause);
        busy         = (state_q != ST_IDLE);
        out_valid    = (state_q == ST_HOLD);

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d      = ST_LOAD;
                    target_d     = iterations;
                    iter_count_d = '0;
                    phase_d      = 8'd0;
                end
            end
            ST_LOAD: begin
                state_d = (target_q == '0) ? ST_HOLD : ST_RUN;
            end
            ST_RUN: begin
                if (!pause) begin
                    if (phase_q == PHASE_LAST) begin
                        phase_d      = 8'd0;
                        iter_count_d = count_inc[ITER_W-1:0];
                        if (count_inc == {1'b0, target_q}) begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything; counters keep the value they had when aborted.
        if (abort) begin
            state_d      = ST_IDLE;
            phase_d      = phase_q;
            iter_count_d = iter_count_q;
            target_d     = target_q;
        end
    end

endmodule
